// File: rtl/jk_bank_driver_if.sv
// Request/bank bus for jk_bank_driver: controller handshake, J/K excitation
// and the Q readback of the driven flip-flop bank.
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH-1:0] q_in;
  logic             En;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_mode, req_target, q_in,
    input  req_ready, En, J, K, done, err
  );

  modport slave (
    input  req_valid, req_mode, req_target, q_in,
    output req_ready, En, J, K, done, err
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops from register-level requests, verifies the
// readback and retries on mismatch. Optional JK_STATS_EN adds op counters.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int RETRY_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  jk_bank_driver_if.slave   bus,
  output logic [1:0]        dbg_state
`ifdef JK_STATS_EN
  ,
  output logic [7:0]        ops_done,
  output logic [7:0]        ops_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] M_LOAD   = 2'b00;
  localparam logic [1:0] M_TOGGLE = 2'b01;
  localparam logic [1:0] M_CLEAR  = 2'b10;
  localparam logic [1:0] M_SET    = 2'b11;
  localparam logic [2:0] RETRY_LIM = 3'(RETRY_MAX);

  state_t           state, state_nx;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] expected_r;
  logic [2:0]       retry_cnt;
  logic             err_r;

  logic             en_c;
  logic [WIDTH-1:0] j_c, k_c;
  logic             match;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; req_ready is high only in IDLE outside reset.
  assign bus.req_ready = (state == IDLE) && reset;
  assign bus.En        = en_c;
  assign bus.J         = j_c;
  assign bus.K         = k_c;
  assign bus.done      = (state == RESP);
  assign bus.err       = (state == RESP) && err_r;
  assign dbg_state     = state;
  assign match         = (bus.q_in == expected_r);

  always_comb begin
    state_nx = state;
    en_c     = 1'b0;
    j_c      = '0;
    k_c      = '0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) state_nx = DRIVE;
      end
      DRIVE: begin
        en_c     = 1'b1;
        state_nx = CHECK;
        // Retries steer straight at expected_r so a TOGGLE never flips twice.
        if (retry_cnt != 3'd0 || mode_r == M_LOAD) begin
          j_c = ~bus.q_in & expected_r;
          k_c = bus.q_in & ~expected_r;
        end else begin
          unique case (mode_r)
            M_TOGGLE: begin
              j_c = target_r;
              k_c = target_r;
            end
            M_CLEAR: k_c = '1;
            M_SET:   j_c = '1;
            default: ;
          endcase
        end
      end
      CHECK: begin
        if (match)                       state_nx = RESP;
        else if (retry_cnt < RETRY_LIM)  state_nx = DRIVE;
        else                             state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_r     <= M_LOAD;
      target_r   <= '0;
      expected_r <= '0;
      retry_cnt  <= 3'd0;
      err_r      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mode_r   <= bus.req_mode;
            target_r <= bus.req_target;
            unique case (bus.req_mode)
              M_LOAD:   expected_r <= bus.req_target;
              M_TOGGLE: expected_r <= bus.q_in ^ bus.req_target;
              M_CLEAR:  expected_r <= '0;
              M_SET:    expected_r <= '1;
              default:  expected_r <= '0;
            endcase
          end
        end
        CHECK: begin
          if (match) begin
            err_r <= 1'b0;
          end else if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + 3'd1;
          end else begin
            err_r <= 1'b1;
          end
        end
        RESP: retry_cnt <= 3'd0;
        default: ;
      endcase
    end
  end

`ifdef JK_STATS_EN
  // Saturating completion counters, split by outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ops_done <= 8'd0;
      ops_err  <= 8'd0;
    end else if (state == RESP) begin
      if (!err_r) begin
        if (ops_done != 8'hFF) ops_done <= ops_done + 8'd1;
      end else begin
        if (ops_err != 8'hFF) ops_err <= ops_err + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver: behavioural JK bank, expected-queue
// scoreboard for drive strobes and completions, final summary.
module tb_jk_bank_driver;
  localparam int WIDTH = 4;
  localparam logic [1:0] M_LOAD   = 2'b00;
  localparam logic [1:0] M_TOGGLE = 2'b01;
  localparam logic [1:0] M_CLEAR  = 2'b10;
  localparam logic [1:0] M_SET    = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jk_bank_driver_if #(.WIDTH(WIDTH)) bus ();
  logic [1:0] dbg_state;
`ifdef JK_STATS_EN
  logic [7:0] ops_done, ops_err;
`endif

  jk_bank_driver #(.WIDTH(WIDTH), .RETRY_MAX(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef JK_STATS_EN
    ,
    .ops_done  (ops_done),
    .ops_err   (ops_err)
`endif
  );

  // ---------------- behavioural flip-flop bank ----------------
  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] stuck_mask;
  assign bus.q_in = q_bank;
  always @(posedge clk)
    if (bus.En) q_bank <= ((bus.J & ~q_bank) | (~bus.K & q_bank)) & ~stuck_mask;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  drv_q[$];   // {J, K} per expected strobe
  logic [20:0] exp_q[$];   // {err, q, done cycle}
  logic [7:0]  d;
  logic [20:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.En) begin
        if (drv_q.size() == 0) check("drive_unexpected", 32'(bus.En), 32'd0);
        else begin
          d = drv_q.pop_front();
          check("drive_J", 32'(bus.J), 32'(d[7:4]));
          check("drive_K", 32'(bus.K), 32'(d[3:0]));
        end
      end else begin
        check("idle_jk_zero", 32'({bus.J, bus.K}), 32'd0);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) check("done_unexpected", 32'(bus.done), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("done_err",   32'(bus.err),  32'(e[20]));
          check("done_q",     32'(bus.q_in), 32'(e[19:16]));
          check("done_cycle", 32'(cyc),      32'(e[15:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_q(input logic [WIDTH-1:0] v);
    q_bank = v;
  endtask

  task automatic send_req(input logic [1:0] mode, input logic [WIDTH-1:0] tgt,
                          input bit track, input logic [WIDTH-1:0] ej,
                          input logic [WIDTH-1:0] ek, input int ndrv,
                          input logic eerr, input logic [WIDTH-1:0] eq);
    int acc;
    bit ok;
    ok = 1'b0;
    acc = 0;
    bus.req_valid  = 1'b1;
    bus.req_mode   = mode;
    bus.req_target = tgt;
    for (int t = 0; t < 40; t++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else if (track) begin
      for (int i = 0; i < ndrv; i++) drv_q.push_back({ej, ek});
      exp_q.push_back({eerr, eq, 16'(acc + 2 + 2 * (ndrv - 1))});
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      drv_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_mode   = M_LOAD;
    bus.req_target = '0;
    stuck_mask     = '0;
    set_q(4'b0000);
    repeat (2) @(negedge clk);

    // Reset held with a request offered
    bus.req_valid = 1'b1;
    bus.req_mode  = M_SET;
    @(negedge clk);
    check("reset_En",    32'(bus.En),        32'd0);
    check("reset_J",     32'(bus.J),         32'd0);
    check("reset_K",     32'(bus.K),         32'd0);
    check("reset_done",  32'(bus.done),      32'd0);
    check("reset_err",   32'(bus.err),       32'd0);
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check("reset_state", 32'(dbg_state),     32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // LOAD 1010 from 0110
    set_q(4'b0110);
    send_req(M_LOAD, 4'b1010, 1'b1, 4'b1000, 4'b0100, 1, 1'b0, 4'b1010);
    wait_idle();

    // TOGGLE 0011 from 1010, then CLEAR (target ignored)
    send_req(M_TOGGLE, 4'b0011, 1'b1, 4'b0011, 4'b0011, 1, 1'b0, 4'b1001);
    wait_idle();
    send_req(M_CLEAR, 4'b0110, 1'b1, 4'b0000, 4'b1111, 1, 1'b0, 4'b0000);
    wait_idle();

    // Bit 0 stuck low: three strobes then err
    stuck_mask = 4'b0001;
    send_req(M_LOAD, 4'b0001, 1'b1, 4'b0001, 4'b0000, 3, 1'b1, 4'b0000);
    wait_idle();
    stuck_mask = 4'b0000;
`ifdef JK_STATS_EN
    check("stats_done_a", 32'(ops_done), 32'd3);
    check("stats_err_a",  32'(ops_err),  32'd1);
`endif

    // Reset during DRIVE
    send_req(M_LOAD, 4'b0101, 1'b0, 4'b0000, 4'b0000, 1, 1'b0, 4'b0000);
    #1;
    check("pre_reset_En", 32'(bus.En), 32'd1);
    check("pre_reset_J",  32'(bus.J),  32'h5);
    reset = 1'b0;
    #1;
    check("abort_En",    32'(bus.En),        32'd0);
    check("abort_J",     32'(bus.J),         32'd0);
    check("abort_K",     32'(bus.K),         32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd0);
    check("abort_state", 32'(dbg_state),     32'd0);
    @(negedge clk);
    check("abort_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
`ifdef JK_STATS_EN
    check("stats_done_clr", 32'(ops_done), 32'd0);
    check("stats_err_clr",  32'(ops_err),  32'd0);
`endif
    send_req(M_LOAD, 4'b0011, 1'b1, 4'b0011, 4'b0000, 1, 1'b0, 4'b0011);
    wait_idle();

    // SET held while busy; accepted only in the IDLE after RESP
    send_req(M_LOAD, 4'b1100, 1'b1, 4'b1100, 4'b0011, 1, 1'b0, 4'b1100);
    bus.req_valid = 1'b1;
    bus.req_mode  = M_SET;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    send_req(M_SET, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1, 1'b0, 4'b1111);
    wait_idle();
`ifdef JK_STATS_EN
    check("stats_done_b", 32'(ops_done), 32'd3);
    check("stats_err_b",  32'(ops_err),  32'd0);
`endif

    repeat (2) @(negedge clk);
    check("drv_q_empty", 32'(drv_q.size()), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
